branch_unit: RTL and testbench
==============================

# branch_unit

Conditional-branch resolution stage that consumes the ALU's comparison flags. It latches `zero`/`less`/`greater` whenever a CMP or TEST retires from execute and evaluates branch conditions against those flags, with same-cycle bypass. On a taken branch it issues a redirect PC and a timed pipeline flush. It also keeps saturating branch/taken counters for performance debug.

## Interface
- `ADDR_WIDTH`, 16, width of PC/target.
- `FLUSH_CYCLES`, 2, cycles `flush` stays high after a taken branch (legal range 1..15).
- `CNT_WIDTH`, 16, width of the statistics counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `flag_we`  in  1  a CMP/TEST result is valid this cycle.
- `zero_in`, `less_in`, `greater_in`  in  1 each  ALU flags, sampled when `flag_we`=1.
- `br_valid`  in  1  branch instruction presented this cycle.
- `br_cond`  in  3  condition: 0 JMP, 1 JEQ, 2 JNE, 3 JL, 4 JLE, 5 JG, 6 JGE, 7 reserved (never taken).
- `br_target`  in  ADDR_WIDTH  branch destination.
- `br_ready`  out  1  unit accepts a branch this cycle (combinational: state==IDLE).
- `flag_z`, `flag_l`, `flag_g`  out  1 each  architectural flag register.
- `take`  out  1  one-cycle pulse: redirect fetch to `target_pc`.
- `target_pc`  out  ADDR_WIDTH  redirect address; holds last taken target.
- `flush`  out  1  squash younger instructions.
- `br_count`, `taken_count`  out  CNT_WIDTH  saturating counters.

## Operation
- Flag register: on `flag_we`=1, load {z,l,g} from inputs; otherwise hold. Flag writes are accepted in every state, including FLUSH.
- Effective flags for evaluation: if `flag_we`=1 in the same cycle as an accepted branch, use the incoming flags (bypass); otherwise use the registered flags.
- Condition evaluation: JMP=1; JEQ=z; JNE=!z; JL=l; JLE=l|z; JG=g; JGE=g|z; code 7=0.
- A branch is accepted when `br_valid`=1 and `br_ready`=1. A `br_valid` seen while `br_ready`=0 is a squashed instruction: it is ignored and not counted.
- State machine:
  - IDLE: if an accepted branch is taken, go to FLUSH and load the flush counter with FLUSH_CYCLES-1. Otherwise stay in IDLE.
  - FLUSH: decrement the counter each cycle. When the counter is 0, return to IDLE.
- Counters:
  - `br_count` increments on every accepted branch.
  - `taken_count` increments on every accepted taken branch.
  - Both saturate at all-ones and never wrap.
- Reset (any time, including mid-FLUSH):
  - state IDLE, flush counter 0.
  - flags 0, `take` 0, `flush` 0, `target_pc` 0.
  - both counters 0.
  - Any in-flight redirect is abandoned.

## Timing
- Branch accepted in cycle N:
  - `take`=1 and `target_pc`=`br_target` are registered and visible in cycle N+1.
  - `take` is high for exactly one cycle.
- `flush` is registered. It is high in cycles N+1 through N+FLUSH_CYCLES inclusive and low in N+FLUSH_CYCLES+1.
- `br_ready` is low during those same FLUSH_CYCLES cycles. The earliest next accepted branch is in cycle N+FLUSH_CYCLES+1.
- Not-taken branch: `take` and `flush` stay 0. `br_ready` stays 1, so back-to-back branches are accepted every cycle.
- `flag_we` in cycle N updates `flag_*` outputs in cycle N+1. The bypass applies only to the branch evaluated in cycle N.
- Counters update in cycle N+1 for a branch accepted in cycle N.

## Test plan
- Reset values: assert `reset` asynchronously mid-cycle -> all outputs 0 and `br_ready`=1 immediately, before the next clock edge.
- Bypass: `flag_we`=1 with z=1,l=0,g=0 together with `br_valid`=1, `br_cond`=1 (JEQ), `br_target`=0x0040 -> next cycle `take`=1, `target_pc`=0x0040, `flag_z`=1. `flush` stays high 2 cycles with FLUSH_CYCLES=2.
- Not taken, back-to-back: flags l=1; JG, then JGE, then JL in 3 consecutive cycles ->
  - the first two are not taken, the third is taken;
  - `br_count`=3, `taken_count`=1;
  - `br_ready` stays 1 until the cycle after the JL.
- Squash during flush: JMP to 0x1234, then `br_valid`=1 JMP to 0x5678 in the next cycle -> the second branch is ignored; `target_pc` stays 0x1234 and `br_count`=1.
- Reset mid-flush: set FLUSH_CYCLES=4, take a JMP, then assert `reset` 2 cycles later -> `flush`=0, state IDLE, counters 0; a branch in the cycle after reset is released is accepted.
- Saturation: set CNT_WIDTH=4 and issue 20 JMPs spaced to respect `br_ready` -> `br_count`=15 and `taken_count`=15, with no wrap.

Source files
------------

// File: rtl/branch_unit.sv
// branch_unit: resolves conditional branches against the ALU flag register and issues a redirect plus timed flush.
// Latency: take/target_pc/flush one cycle after acceptance; flags and counters one cycle after their update.
// Backpressure: br_ready is low for FLUSH_CYCLES cycles after a taken branch; branches offered then are dropped.
module branch_unit #(
    parameter int ADDR_WIDTH   = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flag_we,
    input  logic                  zero_in,
    input  logic                  less_in,
    input  logic                  greater_in,
    input  logic                  br_valid,
    input  logic [2:0]            br_cond,
    input  logic [ADDR_WIDTH-1:0] br_target,
    output logic                  br_ready,
    output logic                  flag_z,
    output logic                  flag_l,
    output logic                  flag_g,
    output logic                  take,
    output logic [ADDR_WIDTH-1:0] target_pc,
    output logic                  flush,
    output logic [CNT_WIDTH-1:0]  br_count,
    output logic [CNT_WIDTH-1:0]  taken_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Counter is loaded with FLUSH_CYCLES-1 so that flush covers exactly FLUSH_CYCLES cycles.
    localparam logic [3:0]           FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    state_t     state;
    logic [3:0] flush_cnt;
    logic       accept;
    logic       eff_z;
    logic       eff_l;
    logic       eff_g;
    logic       cond_true;
    logic       taken;

    assign br_ready = (state == IDLE);
    assign accept   = br_valid && br_ready;
    assign taken    = accept && cond_true;

    // Pick effective flags (same-cycle bypass on flag_we) and evaluate the branch condition.
    always_comb begin
        eff_z     = flag_we ? zero_in    : flag_z;
        eff_l     = flag_we ? less_in    : flag_l;
        eff_g     = flag_we ? greater_in : flag_g;
        cond_true = 1'b0;
        case (br_cond)
            3'd0:    cond_true = 1'b1;
            3'd1:    cond_true = eff_z;
            3'd2:    cond_true = !eff_z;
            3'd3:    cond_true = eff_l;
            3'd4:    cond_true = eff_l || eff_z;
            3'd5:    cond_true = eff_g;
            3'd6:    cond_true = eff_g || eff_z;
            default: cond_true = 1'b0;
        endcase
    end

    // Architectural flag register; writes are accepted in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_z <= 1'b0;
            flag_l <= 1'b0;
            flag_g <= 1'b0;
        end else if (flag_we) begin
            flag_z <= zero_in;
            flag_l <= less_in;
            flag_g <= greater_in;
        end
    end

    // Redirect/flush FSM with registered take, target_pc and flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
            take      <= 1'b0;
            flush     <= 1'b0;
            target_pc <= '0;
        end else begin
            take <= 1'b0;
            case (state)
                IDLE: begin
                    if (taken) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                        take      <= 1'b1;
                        flush     <= 1'b1;
                        target_pc <= br_target;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    flush <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics counters for accepted and taken branches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            if (accept && (br_count != CNT_MAX)) begin
                br_count <= br_count + CNT_ONE;
            end
            if (taken && (taken_count != CNT_MAX)) begin
                taken_count <= taken_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: two instances (FLUSH_CYCLES=2/CNT_WIDTH=16 and FLUSH_CYCLES=4/CNT_WIDTH=4)
// share one stimulus stream; directed scenarios check fixed values, a random phase checks
// both instances against a cycle-level behavioural model.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flag_we, zi, li, gi, br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_target;

    logic        rdy_a, fz_a, fl_a, fg_a, tk_a, fsh_a;
    logic [15:0] tpc_a, brc_a, tkc_a;
    logic        rdy_b, fz_b, fl_b, fg_b, tk_b, fsh_b;
    logic [15:0] tpc_b;
    logic [3:0]  brc_b, tkc_b;

    logic        rdy[2], fz[2], fl[2], fg[2], tk[2], fsh[2];
    logic [15:0] tpc[2], brc[2], tkc[2];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance.
    int          fcy[2] = '{2, 4};
    int          cap[2] = '{65535, 15};
    bit          mz[2], ml[2], mg[2], mtake[2];
    logic [15:0] mtpc[2];
    int          mrem[2], mbr[2], mtk[2];

    always #5 clk = ~clk;

    branch_unit #(.ADDR_WIDTH(16), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .flag_we(flag_we), .zero_in(zi), .less_in(li), .greater_in(gi),
        .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target), .br_ready(rdy_a),
        .flag_z(fz_a), .flag_l(fl_a), .flag_g(fg_a), .take(tk_a), .target_pc(tpc_a),
        .flush(fsh_a), .br_count(brc_a), .taken_count(tkc_a));

    branch_unit #(.ADDR_WIDTH(16), .FLUSH_CYCLES(4), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .flag_we(flag_we), .zero_in(zi), .less_in(li), .greater_in(gi),
        .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target), .br_ready(rdy_b),
        .flag_z(fz_b), .flag_l(fl_b), .flag_g(fg_b), .take(tk_b), .target_pc(tpc_b),
        .flush(fsh_b), .br_count(brc_b), .taken_count(tkc_b));

    always_comb begin
        rdy[0] = rdy_a;  rdy[1] = rdy_b;
        fz[0]  = fz_a;   fz[1]  = fz_b;
        fl[0]  = fl_a;   fl[1]  = fl_b;
        fg[0]  = fg_a;   fg[1]  = fg_b;
        tk[0]  = tk_a;   tk[1]  = tk_b;
        fsh[0] = fsh_a;  fsh[1] = fsh_b;
        tpc[0] = tpc_a;  tpc[1] = tpc_b;
        brc[0] = brc_a;  brc[1] = {12'd0, brc_b};
        tkc[0] = tkc_a;  tkc[1] = {12'd0, tkc_b};
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mz[i] = 0; ml[i] = 0; mg[i] = 0; mtake[i] = 0;
            mtpc[i] = 16'd0; mrem[i] = 0; mbr[i] = 0; mtk[i] = 0;
        end
    endtask

    // One clock of the spec: mrem = flush cycles still to show, ready when it is zero.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit acc, t, ez, el, eg;
            if (reset) continue;
            acc = br_valid && (mrem[i] == 0);
            ez  = flag_we ? zi : mz[i];
            el  = flag_we ? li : ml[i];
            eg  = flag_we ? gi : mg[i];
            case (br_cond)
                3'd0: t = 1;
                3'd1: t = ez;
                3'd2: t = !ez;
                3'd3: t = el;
                3'd4: t = el | ez;
                3'd5: t = eg;
                3'd6: t = eg | ez;
                default: t = 0;
            endcase
            if (flag_we) begin
                mz[i] = zi; ml[i] = li; mg[i] = gi;
            end
            mtake[i] = acc && t;
            if (mtake[i]) begin
                mtpc[i] = br_target;
                mrem[i] = fcy[i];
            end else if (mrem[i] > 0) begin
                mrem[i] = mrem[i] - 1;
            end
            if (acc && mbr[i] < cap[i]) mbr[i] = mbr[i] + 1;
            if (acc && t && mtk[i] < cap[i]) mtk[i] = mtk[i] + 1;
        end
    endtask

    // Advance one clock; returns at the following falling edge, where inputs are driven and outputs sampled.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        flag_we = 0; zi = 0; li = 0; gi = 0;
        br_valid = 0; br_cond = 3'd0; br_target = 16'd0;
    endtask

    task automatic hard_reset();
        clear_inputs();
        #2 reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic settle();
        clear_inputs();
        for (int k = 0; k < 20 && (mrem[0] != 0 || mrem[1] != 0); k++) cyc();
        n_tests++;
        if (rdy[0] !== 1'b1 || rdy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL settle: br_ready a=%0b b=%0b, required 1/1", rdy[0], rdy[1]);
        end
    endtask

    task automatic test_reset();
        // Reset asserted at time 0, before any clock edge.
        #1;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({tk[i], fsh[i], fz[i], fl[i], fg[i], rdy[i]} !== 6'b000001 || tpc[i] !== 16'd0
                || brc[i] !== 16'd0 || tkc[i] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_init[%0d]: tk/fsh/z/l/g/rdy=%b tpc=%h brc=%0d tkc=%0d, required 000001 0 0 0",
                         i, {tk[i], fsh[i], fz[i], fl[i], fg[i], rdy[i]}, tpc[i], brc[i], tkc[i]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cyc();
        // Make state non-zero, then reset asynchronously mid-cycle.
        flag_we = 1; zi = 1; br_valid = 1; br_cond = 3'd0; br_target = 16'h0abc;
        cyc();
        clear_inputs();
        #2 reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({tk[i], fsh[i], fz[i], fl[i], fg[i], rdy[i]} !== 6'b000001 || tpc[i] !== 16'd0
                || brc[i] !== 16'd0 || tkc[i] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_async[%0d]: tk/fsh/z/l/g/rdy=%b tpc=%h brc=%0d tkc=%0d, required 000001 0 0 0",
                         i, {tk[i], fsh[i], fz[i], fl[i], fg[i], rdy[i]}, tpc[i], brc[i], tkc[i]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_bypass();
        hard_reset();
        flag_we = 1; zi = 1; li = 0; gi = 0;
        br_valid = 1; br_cond = 3'd1; br_target = 16'h0040;
        cyc();
        clear_inputs();
        n_tests++;
        if (tk[0] !== 1'b1 || tpc[0] !== 16'h0040 || fz[0] !== 1'b1 || fsh[0] !== 1'b1 || rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_take: take=%b tpc=%h z=%b flush=%b rdy=%b, required 1 0040 1 1 0",
                     tk[0], tpc[0], fz[0], fsh[0], rdy[0]);
        end
        cyc();
        n_tests++;
        if (tk[0] !== 1'b0 || fsh[0] !== 1'b1 || rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_cycle2: take=%b flush=%b rdy=%b, required 0 1 0", tk[0], fsh[0], rdy[0]);
        end
        cyc();
        n_tests++;
        if (fsh[0] !== 1'b0 || rdy[0] !== 1'b1 || fsh[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_end: flush_a=%b rdy_a=%b flush_b=%b, required 0 1 1", fsh[0], rdy[0], fsh[1]);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        hard_reset();
        flag_we = 1; li = 1;
        cyc();
        clear_inputs();
        br_valid = 1; br_cond = 3'd5; br_target = 16'h0010;
        cyc();
        n_tests++;
        if (tk[0] !== 1'b0 || rdy[0] !== 1'b1 || fl[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_jg: take=%b rdy=%b l=%b, required 0 1 1", tk[0], rdy[0], fl[0]);
        end
        br_cond = 3'd6; br_target = 16'h0020;
        cyc();
        n_tests++;
        if (tk[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_jge: take=%b rdy=%b, required 0 1", tk[0], rdy[0]);
        end
        br_cond = 3'd3; br_target = 16'h0100;
        cyc();
        clear_inputs();
        n_tests++;
        if (tk[0] !== 1'b1 || rdy[0] !== 1'b0 || tpc[0] !== 16'h0100 || brc[0] !== 16'd3 || tkc[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_jl: take=%b rdy=%b tpc=%h brc=%0d tkc=%0d, required 1 0 0100 3 1",
                     tk[0], rdy[0], tpc[0], brc[0], tkc[0]);
        end
        settle();
    endtask

    task automatic test_squash();
        hard_reset();
        br_valid = 1; br_cond = 3'd0; br_target = 16'h1234;
        cyc();
        br_target = 16'h5678;
        cyc();
        clear_inputs();
        cyc();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (tpc[i] !== 16'h1234 || brc[i] !== 16'd1 || tkc[i] !== 16'd1) begin
                n_fail++;
                $display("FAIL squash[%0d]: tpc=%h brc=%0d tkc=%0d, required 1234 1 1", i, tpc[i], brc[i], tkc[i]);
            end
        end
        settle();
    endtask

    task automatic test_reset_midflush();
        hard_reset();
        br_valid = 1; br_cond = 3'd0; br_target = 16'h0200;
        cyc();
        clear_inputs();
        cyc();
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (fsh[1] !== 1'b0 || rdy[1] !== 1'b1 || tk[1] !== 1'b0 || brc[1] !== 16'd0 || tkc[1] !== 16'd0
            || tpc[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL midflush_reset: flush=%b rdy=%b take=%b brc=%0d tkc=%0d tpc=%h, required 0 1 0 0 0 0000",
                     fsh[1], rdy[1], tk[1], brc[1], tkc[1], tpc[1]);
        end
        @(negedge clk);
        reset = 1'b0;
        br_valid = 1; br_cond = 3'd0; br_target = 16'h0300;
        cyc();
        clear_inputs();
        n_tests++;
        if (tk[1] !== 1'b1 || tpc[1] !== 16'h0300 || brc[1] !== 16'd1) begin
            n_fail++;
            $display("FAIL midflush_after: take=%b tpc=%h brc=%0d, required 1 0300 1", tk[1], tpc[1], brc[1]);
        end
        settle();
    endtask

    task automatic test_saturation();
        hard_reset();
        for (int k = 0; k < 20; k++) begin
            br_valid = 1; br_cond = 3'd0; br_target = 16'(k);
            cyc();
            br_valid = 0;
            repeat (4) cyc();
        end
        n_tests++;
        if (brc[1] !== 16'd15 || tkc[1] !== 16'd15) begin
            n_fail++;
            $display("FAIL sat_cnt4: brc=%0d tkc=%0d, required 15 15", brc[1], tkc[1]);
        end
        n_tests++;
        if (brc[0] !== 16'd20 || tkc[0] !== 16'd20) begin
            n_fail++;
            $display("FAIL sat_cnt16: brc=%0d tkc=%0d, required 20 20", brc[0], tkc[0]);
        end
    endtask

    task automatic test_random();
        hard_reset();
        for (int c = 0; c < 600; c++) begin
            flag_we   = ($urandom_range(0, 2) == 0);
            zi        = 1'($urandom);
            li        = 1'($urandom);
            gi        = 1'($urandom);
            br_valid  = ($urandom_range(0, 1) == 1);
            br_cond   = 3'($urandom_range(0, 7));
            br_target = 16'($urandom);
            cyc();
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if ({tk[i], fsh[i], rdy[i], fz[i], fl[i], fg[i]} !==
                        {mtake[i], mrem[i] > 0, mrem[i] == 0, mz[i], ml[i], mg[i]}
                    || tpc[i] !== mtpc[i] || brc[i] !== 16'(mbr[i]) || tkc[i] !== 16'(mtk[i])) begin
                    n_fail++;
                    $display("FAIL random[%0d] cyc %0d: tk/fsh/rdy/z/l/g=%b tpc=%h brc=%0d tkc=%0d, required %b%b%b%b%b%b %h %0d %0d",
                             i, c, {tk[i], fsh[i], rdy[i], fz[i], fl[i], fg[i]}, tpc[i], brc[i], tkc[i],
                             mtake[i], mrem[i] > 0, mrem[i] == 0, mz[i], ml[i], mg[i], mtpc[i], mbr[i], mtk[i]);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_bypass();
        test_back_to_back();
        test_squash();
        test_reset_midflush();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
